inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader_pkg.sv | 23 ++
 rtl/inst_loader_if.sv | 39 +++
 rtl/inst_loader_byte_assembler.sv | 59 +++++
 rtl/inst_loader.sv | 131 +++++++++++++
 tb/tb_inst_loader.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_loader_pkg.sv
// ---------------------------------------------------------------------------
// inst_loader_pkg
// Shared definitions for the boot-time instruction loader and its bench:
//   WORD_W        - width of an instruction word / memory data bus
//   ST_*          - loader FSM state encoding
//   next_word_addr- byte address of the word following a given word
// ---------------------------------------------------------------------------
package inst_loader_pkg;

    localparam int WORD_W = 32;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RECV  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    // Word addresses step by four bytes and simply wrap at 2^32.
    function automatic logic [WORD_W-1:0] next_word_addr(input logic [WORD_W-1:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// ---------------------------------------------------------------------------
// inst_loader_if
// Bundles the loader's serial byte stream and its instruction-memory write
// port.
//   byte_valid/byte_data/byte_ready - byte stream, transfer on valid & ready
//   mem_we/mem_addr/mem_wdata       - one-cycle word write to memory
// Modports:
//   master - the loader: consumes bytes, drives the memory write port
//   slave  - the environment: supplies bytes, observes memory writes
// ---------------------------------------------------------------------------
interface inst_loader_if;
    import inst_loader_pkg::*;

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/inst_loader_byte_assembler.sv
// ---------------------------------------------------------------------------
// byte_assembler
// Packs a most-significant-byte-first stream into 32-bit words.
//   clock, reset - clock and asynchronous active-high reset
//   shift_en     - accept byte_in this cycle
//   clear        - restart packing at byte 0 of a fresh word
//   byte_in      - incoming byte
//   word_out     - assembly register with the incoming byte already merged
//                  in when shift_en is high, so the complete word is visible
//                  in the same cycle as the fourth byte
//   count        - index of the next byte within the word (0..3)
//   word_done    - fourth byte of a word is being accepted
// ---------------------------------------------------------------------------
module byte_assembler
    import inst_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              clear,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_out,
    output logic [1:0]        count,
    output logic              word_done
);

    logic [WORD_W-1:0] asm_q;

    // Byte k of a word lands in bits [31-8k:24-8k]; the merged view is what
    // the register takes on the next edge.
    always_comb begin
        word_out = asm_q;
        if (shift_en) begin
            case (count)
                2'd0:    word_out[31:24] = byte_in;
                2'd1:    word_out[23:16] = byte_in;
                2'd2:    word_out[15:8]  = byte_in;
                default: word_out[7:0]   = byte_in;
            endcase
        end
    end

    assign word_done = shift_en && (count == 2'd3);

    // Count wraps 3 -> 0 naturally, which starts the next word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            asm_q <= '0;
            count <= 2'd0;
        end else if (clear) begin
            asm_q <= '0;
            count <= 2'd0;
        end else if (shift_en) begin
            asm_q <= word_out;
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// ---------------------------------------------------------------------------
// inst_loader
// Receives a program as a serial byte stream, packs it into 32-bit words and
// writes them to consecutive instruction-memory addresses starting at
// BASE_ADDR, holding the CPU in reset until the whole image is in place.
//   clock, reset - clock and asynchronous active-high reset
//   start        - load request, honoured only in IDLE, DONE or ERR
//   len_words    - number of words to load, sampled with start
//   bus          - byte stream in, memory write port out (master modport)
//   cpu_reset    - low only once a load has completed
//   busy         - receiving or writing
//   done         - load completed
//   error        - last request asked for more words than the memory holds
// ---------------------------------------------------------------------------
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int              MEM_WORDS = 256,
    parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000
)
(
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  len_words,
    inst_loader_if.master bus,
    output logic         cpu_reset,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    logic [2:0]        state;
    logic [15:0]       len_q;
    logic [15:0]       word_cnt;
    logic [WORD_W-1:0] addr_q;

    logic [WORD_W-1:0] asm_word;
    logic [1:0]        asm_count;
    logic              word_done;
    logic              shift_en;
    logic              asm_clear;
    logic              can_start;
    logic              len_too_big;
    logic              len_zero;
    logic              last_word;

    // Request decode shared by the FSM and the assembler clear.
    always_comb begin
        can_start   = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
        len_too_big = ({16'd0, len_words} > MEM_WORDS_W);
        len_zero    = (len_words == 16'd0);
        asm_clear   = can_start && !len_too_big && !len_zero;
        shift_en    = (state == ST_RECV) && bus.byte_valid;
        last_word   = (({1'b0, word_cnt} + 17'd1) == {1'b0, len_q});
    end

    byte_assembler u_byte_assembler (
        .clock     (clock),
        .reset     (reset),
        .shift_en  (shift_en),
        .clear     (asm_clear),
        .byte_in   (bus.byte_data),
        .word_out  (asm_word),
        .count     (asm_count),
        .word_done (word_done)
    );

    // Status outputs are pure state decodes; byte_ready follows RECV so a
    // byte offered during WRITE simply waits for the next word.
    always_comb begin
        bus.byte_ready = (state == ST_RECV);
        busy           = (state == ST_RECV) || (state == ST_WRITE);
        done           = (state == ST_DONE);
        error          = (state == ST_ERR);
        cpu_reset      = (state != ST_DONE);
    end

    // Main FSM. The memory port registers load on entry to WRITE so that
    // mem_we, mem_addr and mem_wdata line up for exactly the WRITE cycle and
    // keep their values afterwards. The count qualifier keeps a stray flag
    // from ever writing a partial word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            len_q         <= 16'd0;
            word_cnt      <= 16'd0;
            addr_q        <= BASE_ADDR;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= BASE_ADDR;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (can_start) begin
                        if (len_too_big) begin
                            state <= ST_ERR;
                        end else if (len_zero) begin
                            state <= ST_DONE;
                        end else begin
                            state    <= ST_RECV;
                            len_q    <= len_words;
                            word_cnt <= 16'd0;
                            addr_q   <= BASE_ADDR;
                        end
                    end
                end
                ST_RECV: begin
                    if (word_done && (asm_count == 2'd3)) begin
                        state         <= ST_WRITE;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= addr_q;
                        bus.mem_wdata <= asm_word;
                    end
                end
                ST_WRITE: begin
                    addr_q   <= next_word_addr(addr_q);
                    word_cnt <= word_cnt + 16'd1;
                    state    <= last_word ? ST_DONE : ST_RECV;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_loader
// Self-checking bench for inst_loader. A queue of expected memory writes is
// built from the program byte stream and the requested length; a compare
// process checks every write, the hold behaviour of the write port and the
// cpu_reset/done relationship on each falling edge. Directed scenarios add
// literal expectations for timing and data.
// ---------------------------------------------------------------------------
module tb_inst_loader;
    import inst_loader_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] len_words;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    inst_loader_if bus();

    inst_loader #(
        .MEM_WORDS (256),
        .BASE_ADDR (BASE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .len_words (len_words),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [7:0]  stream [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h04};

    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    logic [31:0] seen_addr_q [$];
    logic [31:0] seen_data_q [$];
    int          seen_rel_q [$];
    logic [31:0] hold_addr;
    logic [31:0] hold_data;

    always @(posedge clock) cyc++;

    // Compares one observed value with its required value.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // MSB-first packing of four bytes.
    function automatic logic [31:0] pack_word(input int w);
        return 32'(stream[4*w]) * 32'h0100_0000 + 32'(stream[4*w+1]) * 32'h0001_0000
             + 32'(stream[4*w+2]) * 32'h0000_0100 + 32'(stream[4*w+3]);
    endfunction

    // A load of n words produces n writes at consecutive word addresses.
    task automatic expect_load(input int n);
        for (int w = 0; w < n; w++) begin
            exp_addr_q.push_back(BASE + 32'(4 * w));
            exp_data_q.push_back(pack_word(w));
        end
    endtask

    function automatic int rel_at(input int i);
        return (seen_rel_q.size() > i) ? seen_rel_q[i] : -1;
    endfunction

    function automatic logic [31:0] data_at(input int i);
        return (seen_data_q.size() > i) ? seen_data_q[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] addr_at(input int i);
        return (seen_addr_q.size() > i) ? seen_addr_q[i] : 32'hDEAD_DEAD;
    endfunction

    // Every falling edge outside reset: writes must match the expected queue,
    // the write port holds between writes, and cpu_reset is low only in done.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.mem_we) begin
                if (exp_addr_q.size() == 0) begin
                    checkOutput("spurious_we", 32'(bus.mem_we), 32'd0);
                end else begin
                    checkOutput("wr_addr", bus.mem_addr, exp_addr_q.pop_front());
                    checkOutput("wr_data", bus.mem_wdata, exp_data_q.pop_front());
                end
                hold_addr = bus.mem_addr;
                hold_data = bus.mem_wdata;
                seen_addr_q.push_back(bus.mem_addr);
                seen_data_q.push_back(bus.mem_wdata);
                seen_rel_q.push_back(cyc - start_cyc + 1);
            end else begin
                checkOutput("hold_addr", bus.mem_addr, hold_addr);
                checkOutput("hold_data", bus.mem_wdata, hold_data);
            end
            checkOutput("cpu_reset_vs_done", 32'(cpu_reset), 32'(!done));
            if (bus.byte_ready) checkOutput("ready_implies_busy", 32'(busy), 32'd1);
        end
    end

    // Pulses start for one sampled edge; cycle 1 is the cycle after that edge.
    task automatic applyStimulus(input logic [15:0] len);
        seen_addr_q.delete();
        seen_data_q.delete();
        seen_rel_q.delete();
        start     = 1'b1;
        len_words = len;
        @(posedge clock);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    // Offers one byte and returns just after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        bit taken = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int i = 0; i < 20 && !taken; i++) begin
            @(negedge clock);
            if (bus.byte_ready) taken = 1;
        end
        if (!taken) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(output int rel);
        rel = -1;
        for (int i = 0; i < 60 && rel < 0; i++) begin
            @(negedge clock);
            if (done) rel = cyc - start_cyc + 1;
        end
        if (rel < 0) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        hold_addr = BASE;
        hold_data = 32'd0;
        #1;
        checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, BASE);
        checkOutput("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    int rel;

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        len_words      = 16'd0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        #2;
        do_reset();

        // Scenario 1: two words at full byte rate.
        expect_load(2);
        applyStimulus(16'd2);
        for (int i = 0; i < 8; i++) send_byte(stream[i]);
        bus.byte_valid = 1'b0;
        wait_done(rel);
        checkOutput("s1_done_cycle", 32'(rel), 32'd11);
        checkOutput("s1_cpu_reset", 32'(cpu_reset), 32'd0);
        checkOutput("s1_w0_cycle", 32'(rel_at(0)), 32'd5);
        checkOutput("s1_w1_cycle", 32'(rel_at(1)), 32'd10);
        checkOutput("s1_w0_addr", addr_at(0), 32'h0000_0000);
        checkOutput("s1_w0_data", data_at(0), 32'h2008_0005);
        checkOutput("s1_w1_addr", addr_at(1), 32'h0000_0004);
        checkOutput("s1_w1_data", data_at(1), 32'h8C01_0004);
        checkOutput("s1_queue_empty", 32'(exp_addr_q.size()), 32'd0);

        // Scenario 2: restart from done, 3-cycle stall after the second byte.
        expect_load(2);
        applyStimulus(16'd2);
        checkOutput("s2_restart_cpu_reset", 32'(cpu_reset), 32'd1);
        send_byte(stream[0]);
        send_byte(stream[1]);
        bus.byte_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("s2_stall_busy", 32'(busy), 32'd1);
        for (int i = 2; i < 8; i++) send_byte(stream[i]);
        bus.byte_valid = 1'b0;
        wait_done(rel);
        checkOutput("s2_done_cycle", 32'(rel), 32'd14);
        checkOutput("s2_w0_cycle", 32'(rel_at(0)), 32'd8);
        checkOutput("s2_w1_cycle", 32'(rel_at(1)), 32'd13);
        checkOutput("s2_write_count", 32'(seen_rel_q.size()), 32'd2);

        // Scenario 3: oversize request, then a normal one-word load from ERR.
        applyStimulus(16'd257);
        checkOutput("s3_error", 32'(error), 32'd1);
        checkOutput("s3_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("s3_byte_ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("s3_busy", 32'(busy), 32'd0);
        applyStimulus(16'd300);
        checkOutput("s3_stay_err", 32'(error), 32'd1);
        expect_load(1);
        applyStimulus(16'd1);
        checkOutput("s3_leave_err", 32'(error), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(stream[i]);
        bus.byte_valid = 1'b0;
        wait_done(rel);
        checkOutput("s3_done_cycle", 32'(rel), 32'd6);
        checkOutput("s3_w0_data", data_at(0), 32'h2008_0005);

        // Scenario 4: zero-length request from ERR goes straight to done.
        applyStimulus(16'd257);
        applyStimulus(16'd0);
        checkOutput("s4_done", 32'(done), 32'd1);
        checkOutput("s4_error", 32'(error), 32'd0);
        repeat (3) @(negedge clock);
        checkOutput("s4_no_write", 32'(seen_rel_q.size()), 32'd0);

        // Scenario 5: reset after two bytes of word 1, then a clean reload.
        expect_load(2);
        applyStimulus(16'd2);
        for (int i = 0; i < 6; i++) send_byte(stream[i]);
        bus.byte_valid = 1'b0;
        #2;
        do_reset();
        checkOutput("s5_partial_writes", 32'(seen_rel_q.size()), 32'd1);
        expect_load(2);
        applyStimulus(16'd2);
        for (int i = 0; i < 8; i++) send_byte(stream[i]);
        bus.byte_valid = 1'b0;
        wait_done(rel);
        checkOutput("s5_done_cycle", 32'(rel), 32'd11);
        checkOutput("s5_w0_addr", addr_at(0), 32'h0000_0000);
        checkOutput("s5_w1_data", data_at(1), 32'h8C01_0004);

        // Scenario 6: start pulsed mid-load must not change the length.
        expect_load(2);
        applyStimulus(16'd2);
        send_byte(stream[0]);
        send_byte(stream[1]);
        bus.byte_valid = 1'b0;
        start     = 1'b1;
        len_words = 16'd1;
        @(posedge clock);
        #1;
        start = 1'b0;
        checkOutput("s6_still_busy", 32'(busy), 32'd1);
        for (int i = 2; i < 8; i++) send_byte(stream[i]);
        bus.byte_valid = 1'b0;
        wait_done(rel);
        checkOutput("s6_done_cycle", 32'(rel), 32'd12);
        checkOutput("s6_write_count", 32'(seen_rel_q.size()), 32'd2);
        checkOutput("s6_queue_empty", 32'(exp_addr_q.size()), 32'd0);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
